// File: rtl/vga_pkg.sv
// Shared constants, pixel-position record and pipeline-depth helper for the VGA fetch path.
package vga_pkg;

  localparam int unsigned IMG_W_DEF = 256;
  localparam int unsigned IMG_H_DEF = 256;
  localparam int unsigned SCALE_DEF = 2;

  localparam int unsigned COL_W = 11;
  localparam int unsigned ROW_W = 10;

  // Position of the pixel currently presented by the timing generator.
  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             in_win;
  } pix_pos_t;

  // Input register + fetch + output register, with the memory latency in between.
  function automatic int unsigned pipe_depth(input int unsigned mem_lat);
    return mem_lat + 32'd2;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit reset value.
module vga_delay_line #(
  parameter int unsigned W       = 1,
  parameter int unsigned DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  // Shift one stage per clock; every stage returns to RST_VAL on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Tracks the active-pixel position, fetches replicated image bytes from a
// synchronous framebuffer and drives the DAC with sync/blank realigned.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned SCALE   = SCALE_DEF,
  parameter int unsigned X_OFF   = 64,
  parameter int unsigned Y_OFF   = 0,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter logic [7:0]  BG      = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_blank_n,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_blank_n,
  output logic              o_sync_n,
  output logic              o_frame_done
);

  localparam int unsigned PIPE       = pipe_depth(MEM_LAT);
  localparam int unsigned SYNC_DEPTH = PIPE - 1;
  localparam int unsigned X_SPAN     = IMG_W * SCALE;
  localparam int unsigned Y_SPAN     = IMG_H * SCALE;
  localparam int unsigned REP_W      = 2;

  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [COL_W-1:0]  X_LAST   = COL_W'(X_OFF + X_SPAN - 1);
  localparam logic [ROW_W-1:0]  Y_LAST   = ROW_W'(Y_OFF + Y_SPAN - 1);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              blank_prev_q;
  logic              line_end_c;
  logic              in_x_c;
  logic              in_y_c;
  pix_pos_t          cur;

  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] src_x_q;
  logic [REP_W-1:0]  sx_rep_q;
  logic [REP_W-1:0]  sy_rep_q;

  logic              rd_dly;
  logic [2:0]        sync_dly;
  logic [7:0]        pix_data;
  logic [7:0]        pix_c;

  // Window membership; the subtraction wraps below the offset so one compare covers both bounds.
  assign in_x_c     = (32'(col_q) - X_OFF) < X_SPAN;
  assign in_y_c     = (32'(row_q) - Y_OFF) < Y_SPAN;
  assign line_end_c = blank_prev_q & ~i_blank_n;
  assign cur        = '{col: col_q, row: row_q, in_win: i_blank_n & in_x_c & in_y_c};

  // Column/row counters for the pixel currently on the input; saturate instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      blank_prev_q <= 1'b0;
    end else begin
      blank_prev_q <= i_blank_n;
      if (!i_blank_n)        col_q <= '0;
      else if (col_q != '1)  col_q <= col_q + COL_W'(1);
      if (!i_vs)                          row_q <= '0;
      else if (line_end_c && row_q != '1) row_q <= row_q + ROW_W'(1);
    end
  end

  // Source coordinate walk: each source pixel and row is visited SCALE times.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_base_q <= '0;
      src_x_q    <= '0;
      sx_rep_q   <= '0;
      sy_rep_q   <= '0;
    end else if (!i_vs) begin
      row_base_q <= '0;
      src_x_q    <= '0;
      sx_rep_q   <= '0;
      sy_rep_q   <= '0;
    end else begin
      if (!i_blank_n) begin
        src_x_q  <= '0;
        sx_rep_q <= '0;
      end else if (cur.in_win) begin
        if (sx_rep_q == REP_LAST) begin
          sx_rep_q <= '0;
          src_x_q  <= src_x_q + ADDR_W'(1);
        end else begin
          sx_rep_q <= sx_rep_q + REP_W'(1);
        end
      end
      if (line_end_c && in_y_c) begin
        if (sy_rep_q == REP_LAST) begin
          sy_rep_q   <= '0;
          row_base_q <= row_base_q + ROW_STEP;
        end else begin
          sy_rep_q <= sy_rep_q + REP_W'(1);
        end
      end
    end
  end

  // Framebuffer request and end-of-image marker.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_addr   <= '0;
      o_mem_rd     <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_mem_addr   <= row_base_q + src_x_q;
      o_mem_rd     <= cur.in_win;
      o_frame_done <= cur.in_win && (cur.col == X_LAST) && (cur.row == Y_LAST);
    end
  end

  vga_delay_line #(
    .W      (1),
    .DEPTH  (MEM_LAT),
    .RST_VAL(1'b0)
  ) u_rd_dly (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (o_mem_rd),
    .q    (rd_dly)
  );

  // hs, vs, blank_n arrive one stage ahead of the output register.
  vga_delay_line #(
    .W      (3),
    .DEPTH  (SYNC_DEPTH),
    .RST_VAL(3'b110)
  ) u_sync_dly (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    ({i_hs, i_vs, i_blank_n}),
    .q    (sync_dly)
  );

  // Map framebuffer width onto the 8-bit DAC, keeping the most significant bits.
  if (DATA_W >= 8) begin : g_data_trunc
    assign pix_data = i_mem_data[DATA_W-1 -: 8];
  end else begin : g_data_pad
    localparam int unsigned PAD_W = 8 - DATA_W;
    assign pix_data = {i_mem_data, {PAD_W{1'b0}}};
  end

  assign pix_c = rd_dly ? pix_data : (sync_dly[0] ? BG : 8'h00);

  // Output register: pixel colour plus realigned sync/blank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_r       <= 8'h00;
      o_g       <= 8'h00;
      o_b       <= 8'h00;
      o_hs      <= 1'b1;
      o_vs      <= 1'b1;
      o_blank_n <= 1'b0;
      o_sync_n  <= 1'b1;
    end else begin
      o_r       <= pix_c;
      o_g       <= pix_c;
      o_b       <= pix_c;
      o_hs      <= sync_dly[2];
      o_vs      <= sync_dly[1];
      o_blank_n <= sync_dly[0];
      o_sync_n  <= sync_dly[2] & sync_dly[1];
    end
  end

endmodule
